// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - single-product vending transaction sequencer
//
// Purpose:
//   Latches a one-hot product selection and its price (0001=1, 0010=2,
//   0100=5, 1000=10). It then accumulates one-hot coins until the balance
//   covers the price, dispenses, and returns change. A cancel returns a
//   full refund instead.
//   All outputs are registered. An event sampled at edge N is visible in
//   cycle N+1.
//
// Optional feature (macro VEND_TIMEOUT_EN):
//   PAY-state inactivity timeout after TIMEOUT_CYCLES cycles with no
//   accepted coin. It behaves like cancel and pulses the timeout port.
//
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   product_code    - one-hot selection, sampled with sel_valid
//   sel_valid       - selection strobe
//   coin_in         - one-hot coin (0001=1, 0010=2, 0100=5, 1000=10)
//   coin_valid      - coin strobe
//   cancel          - cancel request
//   busy            - high whenever the sequencer is not idle
//   balance         - current credit
//   dispense        - product release pulse
//   dispensed_code  - latched code while dispense=1, else 0
//   change_valid    - change/refund pulse
//   change_amount   - change/refund value while change_valid=1, else 0
//   coin_reject     - coin presented in the previous cycle was not accepted
//   timeout         - PAY inactivity pulse (VEND_TIMEOUT_EN only)

module vend_controller #(
    parameter int BAL_W          = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       product_code,
    input  logic             sel_valid,
    input  logic [3:0]       coin_in,
    input  logic             coin_valid,
    input  logic             cancel,
    output logic             busy,
    output logic [BAL_W-1:0] balance,
    output logic             dispense,
    output logic [3:0]       dispensed_code,
    output logic             change_valid,
    output logic [BAL_W-1:0] change_amount,
    output logic             coin_reject
`ifdef VEND_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PAY      = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    // Coins and product prices share the same one-hot value table.
    function automatic logic [BAL_W-1:0] code_value(input logic [3:0] c);
        logic [BAL_W-1:0] v;
        case (c)
            4'b0001: v = BAL_W'(1);
            4'b0010: v = BAL_W'(2);
            4'b0100: v = BAL_W'(5);
            4'b1000: v = BAL_W'(10);
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic is_onehot(input logic [3:0] c);
        return (c != 4'b0000) && ((c & (c - 4'b0001)) == 4'b0000);
    endfunction

    state_t           state_q, state_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic [3:0]       code_q, code_d;
    logic [BAL_W-1:0] price_q, price_d;
    logic             dispense_q, dispense_d;
    logic [3:0]       dcode_q, dcode_d;
    logic             change_valid_q, change_valid_d;
    logic [BAL_W-1:0] change_amount_q, change_amount_d;
    logic             coin_reject_q, coin_reject_d;

    // The sum is one bit wider than the balance so that overflow shows up in the MSB.
    logic [BAL_W:0]   coin_sum;
    logic             coin_ok;

`ifdef VEND_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    assign coin_sum = {1'b0, balance_q} + {1'b0, code_value(coin_in)};
    // A coin is acceptable only if it is one-hot and the balance does not saturate.
    assign coin_ok  = coin_valid && is_onehot(coin_in) && !coin_sum[BAL_W];

    always_comb begin
        state_d         = state_q;
        balance_d       = balance_q;
        code_d          = code_q;
        price_d         = price_q;
        coin_reject_d   = 1'b0;
`ifdef VEND_TIMEOUT_EN
        timeout_d       = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                coin_reject_d = coin_valid;
                if (sel_valid && is_onehot(product_code)) begin
                    state_d = ST_PAY;
                    code_d  = product_code;
                    price_d = code_value(product_code);
                end
            end
            ST_PAY: begin
                if (cancel) begin
                    // Cancel outranks a simultaneous coin. The refund is the
                    // balance as it stands.
                    coin_reject_d = coin_valid;
                    state_d       = ST_CHANGE;
                end else if (coin_ok) begin
                    balance_d = coin_sum[BAL_W-1:0];
                    if (coin_sum[BAL_W-1:0] >= price_q) begin
                        state_d = ST_DISPENSE;
                    end
                end else begin
                    coin_reject_d = coin_valid;
`ifdef VEND_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = ST_CHANGE;
                        timeout_d = 1'b1;
                    end
`endif
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_valid;
                balance_d     = balance_q - price_q;
                state_d       = ST_CHANGE;
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                balance_d     = '0;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output pulses are derived from the state being entered, so they
        // appear in the first cycle of that state.
        dispense_d      = (state_d == ST_DISPENSE);
        dcode_d         = dispense_d ? code_d : 4'b0000;
        change_valid_d  = (state_d == ST_CHANGE) && (balance_d != '0);
        change_amount_d = change_valid_d ? balance_d : '0;
    end

`ifdef VEND_TIMEOUT_EN
    // The counter runs only while PAY continues without an accepted coin.
    // Entry into PAY, any accepted coin, and any exit all clear it.
    always_comb begin
        cnt_d = '0;
        if ((state_q == ST_PAY) && (state_d == ST_PAY) && !coin_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            balance_q       <= '0;
            code_q          <= 4'b0000;
            price_q         <= '0;
            dispense_q      <= 1'b0;
            dcode_q         <= 4'b0000;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            coin_reject_q   <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            cnt_q           <= '0;
            timeout_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            balance_q       <= balance_d;
            code_q          <= code_d;
            price_q         <= price_d;
            dispense_q      <= dispense_d;
            dcode_q         <= dcode_d;
            change_valid_q  <= change_valid_d;
            change_amount_q <= change_amount_d;
            coin_reject_q   <= coin_reject_d;
`ifdef VEND_TIMEOUT_EN
            cnt_q           <= cnt_d;
            timeout_q       <= timeout_d;
`endif
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign balance        = balance_q;
    assign dispense       = dispense_q;
    assign dispensed_code = dcode_q;
    assign change_valid   = change_valid_q;
    assign change_amount  = change_amount_q;
    assign coin_reject    = coin_reject_q;
`ifdef VEND_TIMEOUT_EN
    assign timeout        = timeout_q;
`endif

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - self-checking bench for vend_controller
module tb_vend_controller;

    localparam int TO_CYC = 8;
`ifdef VEND_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int P_IDLE = 0, P_PAY = 1, P_DISP = 2, P_CHG = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] product_code = 4'b0;
    logic       sel_valid = 1'b0;
    logic [3:0] coin_in = 4'b0;
    logic       coin_valid = 1'b0;
    logic       cancel = 1'b0;

    logic       busy, dispense, change_valid, coin_reject;
    logic [7:0] balance, change_amount;
    logic [3:0] dispensed_code;
    logic       s_busy, s_dispense, s_change_valid, s_coin_reject;
    logic [3:0] s_balance, s_change_amount;
    logic [3:0] s_dispensed_code;
`ifdef VEND_TIMEOUT_EN
    logic       timeout, s_timeout;
`endif

    vend_controller #(.BAL_W(8), .TIMEOUT_CYCLES(TO_CYC)) u_big (
        .clk(clk), .rst(rst), .product_code(product_code), .sel_valid(sel_valid),
        .coin_in(coin_in), .coin_valid(coin_valid), .cancel(cancel),
        .busy(busy), .balance(balance), .dispense(dispense),
        .dispensed_code(dispensed_code), .change_valid(change_valid),
        .change_amount(change_amount), .coin_reject(coin_reject)
`ifdef VEND_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    vend_controller #(.BAL_W(4), .TIMEOUT_CYCLES(TO_CYC)) u_small (
        .clk(clk), .rst(rst), .product_code(product_code), .sel_valid(sel_valid),
        .coin_in(coin_in), .coin_valid(coin_valid), .cancel(cancel),
        .busy(s_busy), .balance(s_balance), .dispense(s_dispense),
        .dispensed_code(s_dispensed_code), .change_valid(s_change_valid),
        .change_amount(s_change_amount), .coin_reject(s_coin_reject)
`ifdef VEND_TIMEOUT_EN
        , .timeout(s_timeout)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Transaction-level reference: credit, price and phase in plain integers.
    typedef struct {
        int phase; int bal; int price; int code; int idle;
        int disp; int dcode; int chv; int camt; int rej; int to;
    } mst_t;

    mst_t mb, ms;

    function automatic int value_of(input int c);
        case (c)
            1: return 1;
            2: return 2;
            4: return 5;
            8: return 10;
            default: return 0;
        endcase
    endfunction

    function automatic mst_t step(input mst_t m, input int maxbal, input int pc, input int sv,
                                  input int ci, input int cv, input int cn);
        mst_t n;
        int   v;
        bit   ok;
        n = m;
        n.disp = 0; n.dcode = 0; n.chv = 0; n.camt = 0; n.rej = 0; n.to = 0;
        v = value_of(ci);
        case (m.phase)
            P_IDLE: begin
                n.rej = cv;
                if (sv != 0 && value_of(pc) != 0) begin
                    n.phase = P_PAY; n.code = pc; n.price = value_of(pc); n.idle = 0;
                end
            end
            P_PAY: begin
                ok = (cv != 0) && (cn == 0) && (v != 0) && (m.bal + v <= maxbal);
                n.rej = (cv != 0 && !ok) ? 1 : 0;
                if (cn != 0) begin
                    n.phase = P_CHG; n.chv = (m.bal != 0); n.camt = m.bal;
                end else if (ok) begin
                    n.bal = m.bal + v; n.idle = 0;
                    if (n.bal >= m.price) begin
                        n.phase = P_DISP; n.disp = 1; n.dcode = m.code;
                    end
                end else if (TO_EN && m.idle == TO_CYC - 1) begin
                    n.phase = P_CHG; n.chv = (m.bal != 0); n.camt = m.bal; n.to = 1;
                end else begin
                    n.idle = m.idle + 1;
                end
            end
            P_DISP: begin
                n.rej = cv; n.bal = m.bal - m.price; n.phase = P_CHG;
                n.chv = (n.bal != 0); n.camt = n.bal;
            end
            default: begin
                n.rej = cv; n.bal = 0; n.phase = P_IDLE;
            end
        endcase
        return n;
    endfunction

    task automatic cmp_model;
        chk("big_busy", busy, mb.phase != P_IDLE);
        chk("big_balance", balance, mb.bal);
        chk("big_dispense", dispense, mb.disp);
        chk("big_dcode", dispensed_code, mb.dcode);
        chk("big_change_valid", change_valid, mb.chv);
        chk("big_change_amount", change_amount, mb.camt);
        chk("big_coin_reject", coin_reject, mb.rej);
        chk("small_busy", s_busy, ms.phase != P_IDLE);
        chk("small_balance", s_balance, ms.bal);
        chk("small_dispense", s_dispense, ms.disp);
        chk("small_dcode", s_dispensed_code, ms.dcode);
        chk("small_change_valid", s_change_valid, ms.chv);
        chk("small_change_amount", s_change_amount, ms.camt);
        chk("small_coin_reject", s_coin_reject, ms.rej);
`ifdef VEND_TIMEOUT_EN
        chk("big_timeout", timeout, mb.to);
        chk("small_timeout", s_timeout, ms.to);
`endif
    endtask

    // Called at a falling edge: drive, clock, update models, check at next falling edge.
    task automatic cycle(input logic [3:0] pc, input logic sv, input logic [3:0] ci,
                         input logic cv, input logic cn);
        product_code = pc; sel_valid = sv; coin_in = ci; coin_valid = cv; cancel = cn;
        @(posedge clk);
        mb = step(mb, 255, int'(pc), int'(sv), int'(ci), int'(cv), int'(cn));
        ms = step(ms, 15, int'(pc), int'(sv), int'(ci), int'(cv), int'(cn));
        @(negedge clk);
        product_code = 4'b0; sel_valid = 1'b0; coin_in = 4'b0; coin_valid = 1'b0; cancel = 1'b0;
        cmp_model();
    endtask

    task automatic idle_cycle;
        cycle(4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset applied mid-cycle; outputs are checked before any clock edge.
    task automatic do_reset;
        #1 rst = 1'b1;
        #1;
        mb = '{default: 0};
        ms = '{default: 0};
        cmp_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] pc; logic sv; logic [3:0] ci; logic cv; logic cn;
        int busy; int bal; int disp; int dcode; int chv; int camt; int rej;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] pc, input logic sv, input logic [3:0] ci,
                                input logic cv, input logic cn, input int b, input int bal,
                                input int d, input int dc, input int cv_o, input int ca,
                                input int rj);
        vec_t r;
        r.pc = pc; r.sv = sv; r.ci = ci; r.cv = cv; r.cn = cn;
        r.busy = b; r.bal = bal; r.disp = d; r.dcode = dc; r.chv = cv_o; r.camt = ca; r.rej = rj;
        return r;
    endfunction

    vec_t vecs[$];

    initial begin
        //          pc      sv  ci      cv  cn  busy bal disp dcode chv camt rej
        vecs.push_back(mk(4'b0100, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0010, 1, 0, 1, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0010, 1, 0, 1, 4, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0001, 1, 0, 1, 5, 1, 4, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0001, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b1000, 1, 0, 1, 10, 1, 1, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 1, 9, 0, 0, 1, 9, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1000, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0100, 1, 0, 1, 5, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0010, 1, 0, 1, 7, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0001, 1, 1, 1, 7, 0, 0, 1, 7, 1));
        vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0110, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0010, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0011, 1, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0000, 0, 4'b0001, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1000, 1, 4'b0000, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0001, 1, 0, 1, 2, 1, 2, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 4'b0001, 1, 1, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end

    initial begin
        mb = '{default: 0};
        ms = '{default: 0};
        @(negedge clk);
        do_reset();

        // Directed table (tests 1-4 of the plan)
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].pc, vecs[i].sv, vecs[i].ci, vecs[i].cv, vecs[i].cn);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d_balance", i), balance, vecs[i].bal);
            chk($sformatf("vec%0d_dispense", i), dispense, vecs[i].disp);
            chk($sformatf("vec%0d_dcode", i), dispensed_code, vecs[i].dcode);
            chk($sformatf("vec%0d_change_valid", i), change_valid, vecs[i].chv);
            chk($sformatf("vec%0d_change_amount", i), change_amount, vecs[i].camt);
            chk($sformatf("vec%0d_coin_reject", i), coin_reject, vecs[i].rej);
        end

        // Narrow balance: 5+10 reaches the 15 limit exactly; 8+10 must be rejected
        do_reset();
        cycle(4'b1000, 1'b1, 4'b0, 1'b0, 1'b0);
        cycle(4'b0, 1'b0, 4'b0100, 1'b1, 1'b0);
        cycle(4'b0, 1'b0, 4'b1000, 1'b1, 1'b0);
        chk("sat_exact_dispense", s_dispense, 1);
        chk("sat_exact_balance", s_balance, 15);
        idle_cycle();
        chk("sat_exact_change", s_change_amount, 5);
        idle_cycle();
        cycle(4'b1000, 1'b1, 4'b0, 1'b0, 1'b0);
        cycle(4'b0, 1'b0, 4'b0100, 1'b1, 1'b0);
        cycle(4'b0, 1'b0, 4'b0010, 1'b1, 1'b0);
        cycle(4'b0, 1'b0, 4'b0001, 1'b1, 1'b0);
        cycle(4'b0, 1'b0, 4'b1000, 1'b1, 1'b0);
        chk("sat_ovf_reject", s_coin_reject, 1);
        chk("sat_ovf_balance", s_balance, 8);
        chk("sat_wide_dispense", dispense, 1);
        cycle(4'b0, 1'b0, 4'b0, 1'b0, 1'b1);
        chk("sat_cancel_refund", s_change_amount, 8);
        idle_cycle();
        idle_cycle();

        // Reset in the middle of PAY: credit is discarded, no change pulse follows
        cycle(4'b0100, 1'b1, 4'b0, 1'b0, 1'b0);
        cycle(4'b0, 1'b0, 4'b0010, 1'b1, 1'b0);
        chk("pre_rst_balance", balance, 2);
        do_reset();
        idle_cycle();
        chk("post_rst_no_change", change_valid, 0);
        chk("post_rst_busy", busy, 0);

`ifdef VEND_TIMEOUT_EN
        cycle(4'b0100, 1'b1, 4'b0, 1'b0, 1'b0);
        cycle(4'b0, 1'b0, 4'b0010, 1'b1, 1'b0);
        for (int k = 0; k < TO_CYC - 1; k++) begin
            idle_cycle();
            chk("to_early", timeout, 0);
        end
        idle_cycle();
        chk("to_pulse", timeout, 1);
        chk("to_change_valid", change_valid, 1);
        chk("to_refund", change_amount, 2);
        idle_cycle();
        idle_cycle();
`endif

        // Randomized traffic against the reference model
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] pc, ci;
            logic       sv, cv, cn;
            pc = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
            ci = ($urandom_range(0, 5) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
            sv = ($urandom_range(0, 3) == 0);
            cv = ($urandom_range(0, 2) == 0);
            cn = ($urandom_range(0, 19) == 0);
            cycle(pc, sv, ci, cv, cn);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
